// File: rtl/icache_pkg.sv
// Shared widths, FSM state type and address helper for the direct-mapped instruction cache.
// Default geometry: 4 lines x 4 words, 32-bit byte addresses.
package icache_pkg;

    localparam int LINES          = 4;
    localparam int WORDS_PER_LINE = 4;
    localparam int ADDR_W         = 32;

    localparam int WORD_W   = $clog2(WORDS_PER_LINE);
    localparam int INDEX_W  = $clog2(LINES);
    localparam int OFFSET_W = WORD_W + 2;
    localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    function automatic logic [ADDR_W-1:0] line_addr(input logic [ADDR_W-1:0] addr,
                                                    input int offset_w);
        logic [ADDR_W-1:0] mask;
        mask = '1;
        mask = mask << offset_w;
        return addr & mask;
    endfunction

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage for the instruction cache: combinational read, whole-line synchronous fill.
// A fill arriving together with clear_all still leaves its line valid.
module icache_array #(
    parameter int LINES          = 4,
    parameter int WORDS_PER_LINE = 4,
    parameter int TAG_W          = 26
) (
    input  logic                          clock,
    input  logic                          rst,
    input  logic [$clog2(LINES)-1:0]          rd_index,
    input  logic [$clog2(WORDS_PER_LINE)-1:0] rd_word,
    output logic                          rd_valid,
    output logic [TAG_W-1:0]              rd_tag,
    output logic [31:0]                   rd_data,
    input  logic                          wr_en,
    input  logic [$clog2(LINES)-1:0]      wr_index,
    input  logic [TAG_W-1:0]              wr_tag,
    input  logic [32*WORDS_PER_LINE-1:0]  wr_line,
    input  logic                          set_valid,
    input  logic                          clear_all
);

    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [31:0]      data_q [LINES][WORDS_PER_LINE];

    always_ff @(posedge clock) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            if (clear_all)
                valid_q <= '0;
            if (wr_en && set_valid)
                valid_q[wr_index] <= 1'b1;
        end
    end

    // Tag and data carry no reset; valid alone gates their use.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            tag_q[wr_index] <= wr_tag;
            for (int w = 0; w < WORDS_PER_LINE; w++)
                data_q[wr_index][w] <= wr_line[32*w +: 32];
        end
    end

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_q[rd_index];
    assign rd_data  = data_q[rd_index][rd_word];

endmodule

// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache; hits return in the same cycle, misses stall and fill a line.
// Optional hit/miss counters are enabled with the ICACHE_STATS_EN macro.
//
// state | meaning
// IDLE  | lookups served; a miss captures the line address and moves to REQ
// REQ   | mem_req held with the captured address until mem_ready fills the line
module icache_direct #(
    parameter int LINES          = icache_pkg::LINES,
    parameter int WORDS_PER_LINE = icache_pkg::WORDS_PER_LINE,
    parameter int ADDR_W         = icache_pkg::ADDR_W
) (
    input  logic                         clock,
    input  logic                         rst,
    input  logic [ADDR_W-1:0]            pc,
    input  logic                         req,
    input  logic                         flush,
    output logic [31:0]                  instruction,
    output logic                         stall,
    output logic                         mem_req,
    output logic [ADDR_W-1:0]            mem_addr,
    input  logic                         mem_ready,
    input  logic [32*WORDS_PER_LINE-1:0] mem_line
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]                  hit_count,
    output logic [31:0]                  miss_count
`endif
);

    import icache_pkg::*;

    localparam int WW = $clog2(WORDS_PER_LINE);
    localparam int IW = $clog2(LINES);
    localparam int OW = WW + 2;
    localparam int TW = ADDR_W - IW - OW;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              hit, start, fill;
    logic              rd_valid;
    logic [TW-1:0]     rd_tag;
    logic [31:0]       rd_data;
    logic              unused_pc_bits;

    assign unused_pc_bits = ^pc[1:0];

    icache_array #(
        .LINES          (LINES),
        .WORDS_PER_LINE (WORDS_PER_LINE),
        .TAG_W          (TW)
    ) u_array (
        .clock     (clock),
        .rst       (rst),
        .rd_index  (pc[OW +: IW]),
        .rd_word   (pc[2 +: WW]),
        .rd_valid  (rd_valid),
        .rd_tag    (rd_tag),
        .rd_data   (rd_data),
        .wr_en     (fill),
        .wr_index  (mem_addr_q[OW +: IW]),
        .wr_tag    (mem_addr_q[ADDR_W-1 -: TW]),
        .wr_line   (mem_line),
        .set_valid (1'b1),
        .clear_all (flush)
    );

    assign hit = req && (state_q == IDLE) && rd_valid && (rd_tag == pc[ADDR_W-1 -: TW]);

    always_comb begin
        state_d    = state_q;
        mem_addr_d = mem_addr_q;
        start      = 1'b0;
        fill       = 1'b0;
        case (state_q)
            IDLE: begin
                if (req && !hit && !flush) begin
                    state_d    = REQ;
                    mem_addr_d = line_addr(pc, OW);
                    start      = 1'b1;
                end
            end
            REQ: begin
                if (mem_ready) begin
                    state_d = IDLE;
                    fill    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q    <= IDLE;
            mem_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    assign instruction = hit ? rd_data : 32'h0;
    assign stall       = req && !hit;
    assign mem_req     = (state_q == REQ);
    assign mem_addr    = mem_addr_q;

`ifdef ICACHE_STATS_EN
    always_ff @(posedge clock) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (hit)
                hit_count <= hit_count + 32'd1;
            if (start)
                miss_count <= miss_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_icache_direct.sv
// Self-checking bench for icache_direct: directed test-plan sequence plus randomized traffic,
// compared every cycle against a line-level behavioural model of the cache.
module tb_icache_direct;

    localparam int LINES = 4;
    localparam int WPL   = 4;
    localparam int AW    = 32;
    localparam int LINE_BYTES = 4 * WPL;

    logic              clock = 1'b0;
    logic              rst = 1'b1;
    logic [AW-1:0]     pc = '0;
    logic              req = 1'b0;
    logic              flush = 1'b0;
    logic [31:0]       instruction;
    logic              stall;
    logic              mem_req;
    logic [AW-1:0]     mem_addr;
    logic              mem_ready = 1'b0;
    logic [32*WPL-1:0] mem_line = '0;
`ifdef ICACHE_STATS_EN
    logic [31:0]       hit_count;
    logic [31:0]       miss_count;
`endif

    icache_direct #(.LINES(LINES), .WORDS_PER_LINE(WPL), .ADDR_W(AW)) dut (
        .clock       (clock),
        .rst         (rst),
        .pc          (pc),
        .req         (req),
        .flush       (flush),
        .instruction (instruction),
        .stall       (stall),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ready   (mem_ready),
        .mem_line    (mem_line)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count   (hit_count),
        .miss_count  (miss_count)
`endif
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: which memory line each cache slot holds, plus the outstanding request.
    bit          m_valid [LINES];
    logic [31:0] m_lineno[LINES];
    logic [31:0] m_data  [LINES][WPL];
    bit          m_pend = 1'b0;
    logic [31:0] m_pend_addr = '0;
    int unsigned m_hits = 0;
    int unsigned m_misses = 0;

    function automatic int unsigned slot_of(input logic [31:0] a);
        return (a / LINE_BYTES) % LINES;
    endfunction

    function automatic int unsigned word_of(input logic [31:0] a);
        return (a / 4) % WPL;
    endfunction

    function automatic bit m_hit();
        int unsigned s;
        s = slot_of(pc);
        return req && !m_pend && m_valid[s] && (m_lineno[s] == pc / LINE_BYTES);
    endfunction

    always @(posedge clock) begin
        bit h;
        int unsigned s;
        h = m_hit();
        if (rst) begin
            for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
            m_pend = 1'b0;
            m_pend_addr = '0;
            m_hits = 0;
            m_misses = 0;
        end else begin
            if (h) m_hits++;
            if (flush)
                for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
            if (m_pend) begin
                if (mem_ready) begin
                    s = slot_of(m_pend_addr);
                    m_valid[s]  = 1'b1;
                    m_lineno[s] = m_pend_addr / LINE_BYTES;
                    for (int w = 0; w < WPL; w++) m_data[s][w] = mem_line[32*w +: 32];
                    m_pend = 1'b0;
                end
            end else if (req && !h && !flush) begin
                m_pend = 1'b1;
                m_pend_addr = (pc / LINE_BYTES) * LINE_BYTES;
                m_misses++;
            end
        end
    end

    always @(negedge clock) begin
        bit h;
        if (check_en && !rst) begin
            h = m_hit();
            chk("stall", {31'b0, stall}, {31'b0, req && !h});
            chk("instruction", instruction, h ? m_data[slot_of(pc)][word_of(pc)] : 32'h0);
            chk("mem_req", {31'b0, mem_req}, {31'b0, m_pend});
            if (m_pend) chk("mem_addr", mem_addr, m_pend_addr);
`ifdef ICACHE_STATS_EN
            chk("hit_count", hit_count, m_hits);
            chk("miss_count", miss_count, m_misses);
`endif
        end
    end

    task automatic drive(input bit rs, input bit r, input logic [31:0] p, input bit f,
                         input bit rdy, input logic [32*WPL-1:0] ln);
        @(posedge clock);
        #1;
        rst = rs; req = r; pc = p; flush = f; mem_ready = rdy; mem_line = ln;
    endtask

    localparam logic [127:0] LINE0  = 128'h00000004_00000003_00000002_00000001;
    localparam logic [127:0] LINE40 = 128'h40000004_40000003_40000002_40000001;
    localparam logic [127:0] LINE10 = 128'h10000004_10000003_10000002_10000001;

    initial begin
        drive(1, 0, 32'h0, 0, 0, '0);
        check_en = 1'b1;

        // Cold start
        drive(0, 1, 32'h00, 0, 0, '0);
        #2 chk("cold_stall", {31'b0, stall}, 32'd1);
        chk("cold_no_memreq", {31'b0, mem_req}, 32'd0);
        chk("cold_instr_zero", instruction, 32'h0);
        drive(0, 1, 32'h00, 0, 0, '0);
        #2 chk("cold_memreq", {31'b0, mem_req}, 32'd1);
        chk("cold_memaddr", mem_addr, 32'h00);
        drive(0, 1, 32'h00, 0, 0, '0);
        drive(0, 1, 32'h00, 0, 1, LINE0);
        #2 chk("fill_cycle_stall", {31'b0, stall}, 32'd1);
        drive(0, 1, 32'h00, 0, 0, '0);
        #2 chk("cold_hit_stall", {31'b0, stall}, 32'd0);
        chk("cold_hit_instr", instruction, 32'h1);

        // Line reuse
        drive(0, 1, 32'h04, 0, 0, '0);
        #2 chk("reuse_04", instruction, 32'h2);
        chk("reuse_04_memreq", {31'b0, mem_req}, 32'd0);
        drive(0, 1, 32'h08, 0, 0, '0);
        #2 chk("reuse_08", instruction, 32'h3);
        drive(0, 1, 32'h0C, 0, 0, '0);
        #2 chk("reuse_0C", instruction, 32'h4);
        chk("reuse_0C_stall", {31'b0, stall}, 32'd0);

        // Conflict miss on index 0
        drive(0, 1, 32'h40, 0, 0, '0);
        #2 chk("conflict_stall", {31'b0, stall}, 32'd1);
        drive(0, 1, 32'h40, 0, 0, '0);
        #2 chk("conflict_memaddr", mem_addr, 32'h40);
        drive(0, 1, 32'h40, 0, 1, LINE40);
        drive(0, 1, 32'h44, 0, 0, '0);
        #2 chk("conflict_hit", instruction, 32'h40000002);
        drive(0, 1, 32'h00, 0, 0, '0);
        #2 chk("evicted_miss", {31'b0, stall}, 32'd1);

        // Redirect while the 0x00 fill is outstanding
        drive(0, 1, 32'h10, 0, 0, '0);
        #2 chk("redirect_memaddr", mem_addr, 32'h00);
        drive(0, 1, 32'h10, 0, 1, LINE0);
        #2 chk("redirect_memaddr_held", mem_addr, 32'h00);
        drive(0, 1, 32'h10, 0, 0, '0);
        #2 chk("redirect_miss", {31'b0, stall}, 32'd1);
        drive(0, 1, 32'h10, 0, 0, '0);
        #2 chk("redirect_new_addr", mem_addr, 32'h10);
        drive(0, 1, 32'h10, 0, 1, LINE10);
        drive(0, 1, 32'h18, 0, 0, '0);
        #2 chk("redirect_hit", instruction, 32'h10000003);

        // Flush, then flush coinciding with mem_ready
        drive(0, 1, 32'h00, 0, 0, '0);
        #2 chk("pre_flush_hit", instruction, 32'h1);
        drive(0, 0, 32'h00, 1, 0, '0);
        drive(0, 1, 32'h00, 0, 0, '0);
        #2 chk("post_flush_miss", {31'b0, stall}, 32'd1);
        drive(0, 1, 32'h00, 0, 0, '0);
        drive(0, 1, 32'h00, 1, 1, LINE0);
        drive(0, 1, 32'h00, 0, 0, '0);
        #2 chk("flush_fill_kept", instruction, 32'h1);
        chk("flush_fill_stall", {31'b0, stall}, 32'd0);

        // Reset during an outstanding miss
        drive(0, 1, 32'h20, 0, 0, '0);
        drive(0, 1, 32'h20, 0, 0, '0);
        #2 chk("pre_reset_memreq", {31'b0, mem_req}, 32'd1);
        drive(1, 1, 32'h20, 0, 0, '0);
        drive(0, 0, 32'h20, 0, 0, '0);
        #2 chk("reset_memreq_drop", {31'b0, mem_req}, 32'd0);
        chk("reset_memaddr", mem_addr, 32'h0);
`ifdef ICACHE_STATS_EN
        chk("reset_hit_count", hit_count, 32'd0);
        chk("reset_miss_count", miss_count, 32'd0);
`endif
        drive(0, 0, 32'h20, 0, 1, LINE0);
        drive(0, 1, 32'h00, 0, 0, '0);
        #2 chk("aborted_fill_ignored", {31'b0, stall}, 32'd1);
        drive(0, 1, 32'h00, 0, 1, LINE0);
        drive(0, 1, 32'h00, 0, 0, '0);

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            logic [127:0] ln;
            logic [31:0]  p;
            for (int w = 0; w < WPL; w++) ln[32*w +: 32] = $urandom;
            p = ($urandom_range(0, 7) << 4) | $urandom_range(0, 15);
            if ($urandom_range(0, 9) == 0) p[31:24] = 8'($urandom_range(0, 255));
            drive($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 8, p,
                  $urandom_range(0, 99) < 3, $urandom_range(0, 9) < 3, ln);
        end

        drive(0, 0, 32'h0, 0, 0, '0);
        @(posedge clock);
        #2;
        check_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
